// File: rtl/dmem_responder.sv
// Data-RAM responder: one load at a time, returned LATENCY cycles after accept; stores commit in one cycle.
// Loads are backpressured by load_req_ready (low while a load is in flight or during mispredict); stores are never backpressured.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req_valid,
  output logic        load_req_ready,
  input  logic [31:0] load_addr,
  input  logic [2:0]  load_funct3,
  input  logic [6:0]  load_pd,
  input  logic [4:0]  load_rob,
  input  logic        store_valid,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  input  logic [2:0]  store_funct3,
  input  logic [4:0]  rob_head,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [6:0]  resp_pd,
  output logic [4:0]  resp_rob
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W+1:0]  lat_addr;
  logic [2:0]         lat_funct3;
  logic [6:0]         lat_pd;
  logic [4:0]         lat_rob;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               squash;
  logic [4:0]         age_ld;
  logic [4:0]         age_br;
  logic [3:0]         st_be;
  logic [31:0]        st_wdata;
  logic [ADDR_W-1:0]  st_idx;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        ld_ext;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{load_addr[31:ADDR_W+2], store_addr[31:ADDR_W+2]};

  assign load_req_ready = (state == IDLE) && !mispredict;
  assign accept         = load_req_valid && load_req_ready;

  // Ages are distances from the ROB head, so wrap-around compares correctly.
  assign age_ld = lat_rob - rob_head;
  assign age_br = mispredict_tag - rob_head;
  assign squash = mispredict && (state != IDLE) && (age_ld > age_br);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_funct3 <= '0;
      lat_pd     <= '0;
      lat_rob    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr   <= load_addr[ADDR_W+1:0];
            lat_funct3 <= load_funct3;
            lat_pd     <= load_pd;
            lat_rob    <= load_rob;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (squash) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Store lane steering: narrow data is replicated and the byte enables pick the lane.
  assign st_idx = store_addr[ADDR_W+1:2];

  always_comb begin
    st_be    = 4'h0;
    st_wdata = '0;
    case (store_funct3)
      3'b000: begin
        st_be    = 4'b0001 << store_addr[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      3'b001: begin
        st_be    = store_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = store_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (store_valid) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[st_idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
  end

  // Combinational read in RESP: a same-cycle store is not yet written, so the old word is returned.
  assign rd_word = mem[lat_addr[ADDR_W+1:2]];
  assign rd_byte = rd_word[{lat_addr[1:0], 3'b000} +: 8];
  assign rd_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_ext = rd_word;
    case (lat_funct3)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_ext = {24'h0, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_ext = {16'h0, rd_half};
      default: ld_ext = rd_word;
    endcase
  end

  assign resp_valid = (state == RESP) && !squash;
  assign resp_data  = (state == RESP) ? ld_ext  : '0;
  assign resp_pd    = (state == RESP) ? lat_pd  : '0;
  assign resp_rob   = (state == RESP) ? lat_rob : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=2: table of stores/loads plus hand sequences for squash, hazards and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req_valid, load_req_ready;
  logic [31:0] load_addr;
  logic [2:0]  load_funct3;
  logic [6:0]  load_pd;
  logic [4:0]  load_rob;
  logic        store_valid;
  logic [31:0] store_addr, store_data;
  logic [2:0]  store_funct3;
  logic [4:0]  rob_head;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [6:0]  resp_pd;
  logic [4:0]  resp_rob;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .load_req_valid(load_req_valid), .load_req_ready(load_req_ready),
    .load_addr(load_addr), .load_funct3(load_funct3), .load_pd(load_pd), .load_rob(load_rob),
    .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
    .store_funct3(store_funct3), .rob_head(rob_head),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_pd(resp_pd), .resp_rob(resp_rob)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] dat;
    logic [6:0]  pd;
    logic [4:0]  rob;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance to the low phase of the next cycle; inputs are driven here and outputs checked #1 later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    store_valid = 1'b1; store_addr = a; store_data = d; store_funct3 = f3;
    step();
    store_valid = 1'b0;
  endtask

  task automatic present_load(input logic [31:0] a, input logic [2:0] f3,
                              input logic [6:0] pd, input logic [4:0] rob);
    load_req_valid = 1'b1; load_addr = a; load_funct3 = f3; load_pd = pd; load_rob = rob;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [6:0] pd, input logic [4:0] rob, input logic [31:0] exp);
    present_load(a, f3, pd, rob);
    #1 chk({tag, "_rdy_idle"}, 32'(load_req_ready), 32'd1);
    step();
    load_req_valid = 1'b0;
    #1 chk({tag, "_rdy_n1"}, 32'(load_req_ready), 32'd0);
    chk({tag, "_vld_n1"}, 32'(resp_valid), 32'd0);
    step();
    #1 chk({tag, "_vld_n2"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_pd"}, 32'(resp_pd), 32'(pd));
    chk({tag, "_rob"}, 32'(resp_rob), 32'(rob));
    chk({tag, "_rdy_n2"}, 32'(load_req_ready), 32'd0);
    step();
    #1 chk({tag, "_vld_after"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rdy_after"}, 32'(load_req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    load_req_valid = 0; load_addr = 0; load_funct3 = 0; load_pd = 0; load_rob = 0;
    store_valid = 0; store_addr = 0; store_data = 0; store_funct3 = 0;
    rob_head = 0; mispredict = 0; mispredict_tag = 0;

    vecs.push_back('{1, 32'h10, 3'b010, 32'hDEADBEEF, 7'd0, 5'd0});
    vecs.push_back('{0, 32'h10, 3'b010, 32'hDEADBEEF, 7'd5, 5'd3});
    vecs.push_back('{1, 32'h20, 3'b010, 32'h000080F0, 7'd0, 5'd0});
    vecs.push_back('{0, 32'h20, 3'b000, 32'hFFFFFFF0, 7'd6, 5'd4});
    vecs.push_back('{0, 32'h21, 3'b100, 32'h00000080, 7'd7, 5'd5});
    vecs.push_back('{0, 32'h20, 3'b001, 32'hFFFF80F0, 7'd8, 5'd6});
    vecs.push_back('{0, 32'h22, 3'b101, 32'h00000000, 7'd9, 5'd7});
    vecs.push_back('{1, 32'h30, 3'b010, 32'h11223344, 7'd0, 5'd0});
    vecs.push_back('{1, 32'h31, 3'b000, 32'hFFFFFFAB, 7'd0, 5'd0});
    vecs.push_back('{0, 32'h30, 3'b010, 32'h1122AB44, 7'd10, 5'd8});
    vecs.push_back('{1, 32'h32, 3'b001, 32'h1234CAFE, 7'd0, 5'd0});
    vecs.push_back('{0, 32'h30, 3'b010, 32'hCAFEAB44, 7'd11, 5'd9});
    vecs.push_back('{0, 32'h33, 3'b000, 32'hFFFFFFCA, 7'd12, 5'd10});
    vecs.push_back('{0, 32'h30, 3'b101, 32'h0000AB44, 7'd13, 5'd11});
    vecs.push_back('{0, 32'h32, 3'b001, 32'hFFFFCAFE, 7'd14, 5'd12});
    vecs.push_back('{0, 32'h32, 3'b100, 32'h000000FE, 7'd15, 5'd13});
    vecs.push_back('{0, 32'h13, 3'b010, 32'hDEADBEEF, 7'd16, 5'd14});
    vecs.push_back('{0, 32'h410, 3'b010, 32'hDEADBEEF, 7'd17, 5'd15});
    vecs.push_back('{0, 32'h30, 3'b011, 32'hCAFEAB44, 7'd18, 5'd16});

    // Reset state
    @(negedge clk);
    #1 chk("rst_vld", 32'(resp_valid), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_pd", 32'(resp_pd), 32'd0);
    chk("rst_rob", 32'(resp_rob), 32'd0);
    chk("rst_rdy", 32'(load_req_ready), 32'd1);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].st) do_store(vecs[i].addr, vecs[i].dat, vecs[i].f3);
      else do_load($sformatf("vec%0d", i), vecs[i].addr, vecs[i].f3, vecs[i].pd, vecs[i].rob, vecs[i].dat);
    end

    // Store and load accepted on the same edge
    store_valid = 1; store_addr = 32'h40; store_data = 32'h5A5A1234; store_funct3 = 3'b010;
    present_load(32'h40, 3'b010, 7'd20, 5'd1);
    step();
    store_valid = 0; load_req_valid = 0;
    step();
    #1 chk("same_edge_vld", 32'(resp_valid), 32'd1);
    chk("same_edge_data", resp_data, 32'h5A5A1234);
    step();

    // Younger load squashed in WAIT
    rob_head = 5'd30;
    present_load(32'h10, 3'b010, 7'd21, 5'd2);
    step();
    load_req_valid = 0; mispredict = 1; mispredict_tag = 5'd1;
    #1 chk("sqw_rdy_misp", 32'(load_req_ready), 32'd0);
    step();
    mispredict = 0;
    #1 chk("sqw_no_vld", 32'(resp_valid), 32'd0);
    chk("sqw_rdy_idle", 32'(load_req_ready), 32'd1);
    step();
    #1 chk("sqw_no_vld2", 32'(resp_valid), 32'd0);

    // Younger load squashed in RESP
    present_load(32'h10, 3'b010, 7'd22, 5'd2);
    step();
    load_req_valid = 0;
    step();
    mispredict = 1; mispredict_tag = 5'd1;
    #1 chk("sqr_no_vld", 32'(resp_valid), 32'd0);
    step();
    mispredict = 0;
    #1 chk("sqr_rdy", 32'(load_req_ready), 32'd1);
    chk("sqr_no_vld2", 32'(resp_valid), 32'd0);

    // Older load survives a mispredict
    present_load(32'h10, 3'b010, 7'd23, 5'd2);
    step();
    load_req_valid = 0; mispredict = 1; mispredict_tag = 5'd4;
    step();
    mispredict = 0;
    #1 chk("old_vld", 32'(resp_valid), 32'd1);
    chk("old_data", resp_data, 32'hDEADBEEF);
    chk("old_rob", 32'(resp_rob), 32'd2);
    step();

    // Request during a mispredict in IDLE is not accepted
    mispredict = 1; mispredict_tag = 5'd0;
    present_load(32'h10, 3'b010, 7'd24, 5'd3);
    #1 chk("misp_idle_rdy", 32'(load_req_ready), 32'd0);
    step();
    mispredict = 0; load_req_valid = 0;
    step();
    #1 chk("misp_idle_no_vld", 32'(resp_valid), 32'd0);
    rob_head = 5'd0;

    // Store in WAIT is visible; store in RESP is not
    do_store(32'h50, 32'h11111111, 3'b010);
    present_load(32'h50, 3'b010, 7'd25, 5'd4);
    step();
    load_req_valid = 0;
    store_valid = 1; store_addr = 32'h50; store_data = 32'h22222222; store_funct3 = 3'b010;
    step();
    store_valid = 0;
    #1 chk("st_wait_data", resp_data, 32'h22222222);
    step();
    present_load(32'h50, 3'b010, 7'd26, 5'd5);
    step();
    load_req_valid = 0;
    step();
    store_valid = 1; store_addr = 32'h50; store_data = 32'h33333333; store_funct3 = 3'b010;
    #1 chk("st_resp_vld", 32'(resp_valid), 32'd1);
    chk("st_resp_data", resp_data, 32'h22222222);
    step();
    store_valid = 0;
    do_load("st_resp_after", 32'h50, 3'b010, 7'd27, 5'd6, 32'h33333333);

    // Reset while in WAIT drops the load and keeps the RAM
    present_load(32'h10, 3'b010, 7'd28, 5'd7);
    step();
    load_req_valid = 0;
    reset = 1;
    #1 chk("rstw_rdy", 32'(load_req_ready), 32'd1);
    chk("rstw_vld", 32'(resp_valid), 32'd0);
    step();
    reset = 0;
    #1 chk("rstw_vld2", 32'(resp_valid), 32'd0);
    step();
    #1 chk("rstw_vld3", 32'(resp_valid), 32'd0);
    do_load("rstw_ram", 32'h10, 3'b010, 7'd29, 5'd8, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
